// File: rtl/annealed_inv_ripple_adder.sv
// annealed_inv_ripple_adder: 4-bit invertible p-bit ripple-carry adder.
// Define ANNEAL_EN to ramp I_0 from I_min to I_max; otherwise I_0 = I_max.
module annealed_inv_ripple_adder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       update_mode,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] sum,
    input  logic [3:0] log_tau,
    input  logic [3:0] I_min,
    input  logic [3:0] I_max,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic [3:0] sum_out,
    output logic       overflow
);
    // p-bit layout: [3:0] a, [7:4] b, [11:8] s, [15:12] c1..c4
    localparam logic [15:0] SEED_BASE = 16'hACE1;
    localparam logic [15:0] SEED_STEP = 16'h0137;

    // floor(256/(1+exp(0.25*I_0*dE))) clamped to 1..255, indexed by I_0
    localparam logic [7:0] T_POS1 [16] = '{
        8'd128, 8'd112, 8'd96, 8'd82, 8'd68, 8'd57, 8'd46, 8'd37,
        8'd30, 8'd24, 8'd19, 8'd15, 8'd12, 8'd9, 8'd7, 8'd5};
    localparam logic [7:0] T_NEG1 [16] = '{
        8'd128, 8'd143, 8'd159, 8'd173, 8'd187, 8'd198, 8'd209, 8'd218,
        8'd225, 8'd231, 8'd236, 8'd240, 8'd243, 8'd246, 8'd248, 8'd250};
    localparam logic [7:0] T_POS2 [16] = '{
        8'd128, 8'd96, 8'd68, 8'd46, 8'd30, 8'd19, 8'd12, 8'd7,
        8'd4, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    localparam logic [7:0] T_NEG2 [16] = '{
        8'd128, 8'd159, 8'd187, 8'd209, 8'd225, 8'd236, 8'd243, 8'd248,
        8'd251, 8'd253, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255};

    logic [15:0] pbit_q;
    logic [15:0] pbit_d;
    logic [15:0] lfsr_q [16];
    logic [15:0] lfsr_d [16];
    logic [3:0]  ptr_q;
    logic [3:0]  ptr_d;
    logic [15:0] clamp_en;
    logic [15:0] clamp_val;
    logic [3:0]  i0_cur;

    // Number of inconsistent full-adder stages for a full p-bit state
    function automatic logic [2:0] energy(input logic [15:0] st);
        logic [2:0] e;
        logic       x;
        logic       y;
        logic       s;
        logic       ci;
        logic       co;
        e = 3'd0;
        for (int i = 0; i < 4; i++) begin
            x  = st[i];
            y  = st[4+i];
            s  = st[8+i];
            co = st[12+i];
            ci = (i == 0) ? 1'b0 : st[11+i];
            if ((s != (x ^ y ^ ci)) ||
                (co != ((x & y) | (ci & (x ^ y)))))
                e = e + 3'd1;
        end
        return e;
    endfunction

    // Energy change of setting bit k to 1 versus 0; only the stages
    // touching that bit differ, so the result lies in -2..+2
    function automatic logic signed [3:0] delta_e(
        input logic [15:0] st,
        input logic [3:0]  k
    );
        logic [15:0] hi;
        logic [15:0] lo;
        hi    = st;
        hi[k] = 1'b1;
        lo    = st;
        lo[k] = 1'b0;
        return $signed({1'b0, energy(hi)}) - $signed({1'b0, energy(lo)});
    endfunction

    function automatic logic [7:0] threshold(
        input logic signed [3:0] de,
        input logic [3:0]        i0
    );
        logic [7:0] t;
        case (de)
            -4'sd2:  t = T_NEG2[i0];
            -4'sd1:  t = T_NEG1[i0];
            4'sd1:   t = T_POS1[i0];
            4'sd2:   t = T_POS2[i0];
            default: t = 8'd128;
        endcase
        return t;
    endfunction

    // Which p-bits are pinned to inputs for each operating mode
    always_comb begin
        clamp_en  = '0;
        clamp_val = '0;
        unique case (mode)
            2'd0: begin
                clamp_en  = 16'h00ff;
                clamp_val = {8'h00, b, a};
            end
            2'd1: begin
                clamp_en  = 16'h8f00;
                clamp_val = {4'h0, sum, 8'h00};
            end
            2'd2: begin
                clamp_en  = 16'h8f0f;
                clamp_val = {4'h0, sum, 4'h0, a};
            end
            default: ;
        endcase
    end

    // Gibbs-style p-bit update plus per-bit LFSR advance and sweep pointer
    always_comb begin
        pbit_d = pbit_q;
        ptr_d  = update_mode ? ptr_q : ptr_q + 4'd1;
        for (int k = 0; k < 16; k++) begin
            lfsr_d[k] = {lfsr_q[k][14:0],
                         lfsr_q[k][15] ^ lfsr_q[k][14] ^
                         lfsr_q[k][12] ^ lfsr_q[k][3]};
            if (update_mode || (ptr_q == 4'(k))) begin
                if (clamp_en[k])
                    pbit_d[k] = clamp_val[k];
                else
                    pbit_d[k] = lfsr_q[k][7:0] <
                        threshold(delta_e(pbit_q, 4'(k)), i0_cur);
            end
        end
    end

    // p-bit, LFSR and pointer state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pbit_q <= '0;
            ptr_q  <= '0;
            for (int k = 0; k < 16; k++)
                lfsr_q[k] <= SEED_BASE + SEED_STEP * 16'(k);
        end else begin
            pbit_q <= pbit_d;
            ptr_q  <= ptr_d;
            for (int k = 0; k < 16; k++)
                lfsr_q[k] <= lfsr_d[k];
        end
    end

`ifdef ANNEAL_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] tau_last;
    logic [3:0]  step_q;
    logic [3:0]  step_d;
    logic [4:0]  i0_sum;

    // I_0 is I_min plus completed steps, saturated at I_max
    always_comb begin
        i0_sum = {1'b0, I_min} + {1'b0, step_q};
        if (I_min >= I_max)
            i0_cur = I_min;
        else if (i0_sum >= {1'b0, I_max})
            i0_cur = I_max;
        else
            i0_cur = i0_sum[3:0];
    end

    // Take one schedule step every 2^log_tau cycles
    always_comb begin
        tau_last = (16'd1 << log_tau) - 16'd1;
        cnt_d    = cnt_q + 16'd1;
        step_d   = step_q;
        if (cnt_q == tau_last) begin
            cnt_d = '0;
            if (i0_cur < I_max)
                step_d = step_q + 4'd1;
        end
    end

    // Annealer state, restarted only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            step_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end
`else
    logic unused_anneal;
    assign unused_anneal = ^{log_tau, I_min};
    assign i0_cur = I_max;
`endif

    assign a_out    = pbit_q[3:0];
    assign b_out    = pbit_q[7:4];
    assign sum_out  = pbit_q[11:8];
    assign overflow = pbit_q[15];
endmodule

// File: tb/tb_annealed_inv_ripple_adder.sv
// tb_annealed_inv_ripple_adder: directed bench with a scoreboard queue
// of expected clamp values, annealer model and reset replay trace.
module tb_annealed_inv_ripple_adder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       update_mode = 1'b1;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic [3:0] sum = 4'd0;
    logic [3:0] log_tau = 4'd0;
    logic [3:0] I_min = 4'd0;
    logic [3:0] I_max = 4'd0;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [3:0] sum_out;
    logic       overflow;
    logic [12:0] obs;

    typedef struct {
        logic [12:0] mask;
        logic [12:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [12:0] ref_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ones [13];
    int          hits;

    assign obs = {overflow, sum_out, b_out, a_out};

    always #5 clk = ~clk;

    annealed_inv_ripple_adder dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .update_mode(update_mode),
        .a(a),
        .b(b),
        .sum(sum),
        .log_tau(log_tau),
        .I_min(I_min),
        .I_max(I_max),
        .a_out(a_out),
        .b_out(b_out),
        .sum_out(sum_out),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic int exp_i0(input int edges, input int imin,
                                  input int imax, input int lt);
        int v;
`ifdef ANNEAL_EN
        if (imin >= imax) return imin;
        v = imin + edges / (1 << lt);
        if (v > imax) v = imax;
`else
        v = imax;
        if (edges < 0 || imin < 0 || lt < 0) v = 0;
`endif
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_outputs", 32'(obs), 32'd0);
        #2 reset = 1'b0;
    endtask

    task automatic run_phase(input string tag, input int warm, input int n,
                             input logic [12:0] mask,
                             input logic [12:0] val);
        exp_t e;
        for (int i = 0; i < 13; i++) ones[i] = 0;
        hits = 0;
        for (int c = 0; c < warm + n; c++) begin
            if (c >= warm) sb_q.push_back('{mask, val & mask});
            tick();
            if (c >= warm) begin
                e = sb_q.pop_front();
                chk({tag, "_clamp"}, 32'(obs & e.mask), 32'(e.val));
                for (int i = 0; i < 13; i++)
                    if (obs[i]) ones[i]++;
                if (5'(a_out) + 5'(b_out) == 5'd12) hits++;
            end
        end
    endtask

    function automatic logic [3:0] maj4(input int base, input int n);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (ones[base+i] * 2 > n);
        return m;
    endfunction

    initial begin
        exp_t e;

        mode = 2'd0; update_mode = 1'b1; a = 4'd1; b = 4'd7;
        I_min = 4'd2; I_max = 4'd15; log_tau = 4'd8;
        do_reset();
        chk("i0_reset", 32'(dut.i0_cur), 32'(exp_i0(0, 2, 15, 8)));
        for (int c = 1; c <= 800; c++) begin
            if (c == 513) begin
                mode = 2'd2; a = 4'd3; sum = 4'd12;
            end
            if (c < 513) sb_q.push_back('{13'h00ff, 13'h0071});
            else sb_q.push_back('{13'h1f0f, 13'h0c03});
            tick();
            e = sb_q.pop_front();
            chk("anneal_clamp", 32'(obs & e.mask), 32'(e.val));
            if (c == 255 || c == 256 || c == 767 || c == 768 || c == 800)
                chk($sformatf("i0_edge%0d", c), 32'(dut.i0_cur),
                    32'(exp_i0(c, 2, 15, 8)));
        end

        mode = 2'd0; a = 4'd1; b = 4'd7;
        I_min = 4'd2; I_max = 4'd4; log_tau = 4'd0;
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1 || c == 2 || c == 5)
                chk($sformatf("i0_tau0_edge%0d", c), 32'(dut.i0_cur),
                    32'(exp_i0(c, 2, 4, 0)));
        end

        I_min = 4'd9; I_max = 4'd6;
        do_reset();
        tick(); tick(); tick();
        chk("i0_min_ge_max", 32'(dut.i0_cur), 32'(exp_i0(3, 9, 6, 0)));

        I_min = 4'd2; I_max = 4'd15; log_tau = 4'd4;
        update_mode = 1'b1;
        do_reset();
        run_phase("fwd_par", 400, 1000, 13'h00ff, 13'h0071);
        chk("fwd_par_sum_maj", 32'(maj4(8, 1000)), 32'h8);
        chk("fwd_par_ov_maj", 32'(ones[12] * 2 > 1000), 32'd0);

        update_mode = 1'b0;
        do_reset();
        tick();
        chk("seq_a_edge1", 32'(a_out), 32'd1);
        for (int c = 2; c <= 6; c++) tick();
        chk("seq_b_edge6", 32'(b_out), 32'd3);
        tick();
        chk("seq_b_edge7", 32'(b_out), 32'd7);
        run_phase("fwd_seq", 400, 1000, 13'h00ff, 13'h0071);
        chk("fwd_seq_sum_maj", 32'(maj4(8, 1000)), 32'h8);

        mode = 2'd2; a = 4'd3; sum = 4'd12;
        do_reset();
        run_phase("sub_seq", 400, 1000, 13'h1f0f, 13'h0c03);
        chk("sub_seq_b_maj", 32'(maj4(4, 1000)), 32'h9);

        mode = 2'd1; sum = 4'd12;
        do_reset();
        run_phase("inv_seq", 400, 1000, 13'h1f00, 13'h0c00);
        chk("inv_seq_hits", 32'(hits * 2 > 1000), 32'd1);

        update_mode = 1'b1; log_tau = 4'd2;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            tick();
            ref_q.push_back(obs);
        end
        for (int c = 0; c < 23; c++) tick();
        chk("pre_reset_busy", 32'(sum_out), 32'd12);
        do_reset();
        chk("i0_after_rst", 32'(dut.i0_cur), 32'(exp_i0(0, 2, 15, 2)));
        for (int c = 0; c < 40; c++) begin
            tick();
            chk($sformatf("replay%0d", c), 32'(obs), 32'(ref_q.pop_front()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
